// File: rtl/dstack_if.sv
// Stack-control bundle between the instruction decode (master) and the data stack (slave).
interface dstack_if #(
   parameter int WORD_WIDTH = 32
);
   logic                  stall;
   logic [1:0]            movement;
   logic [WORD_WIDTH-1:0] next_top;
   logic                  rotate;
   logic [5:0]            rotate_addr;
   logic [WORD_WIDTH-1:0] top;
   logic [WORD_WIDTH-1:0] second;
   logic [WORD_WIDTH-1:0] third;
   logic [WORD_WIDTH-1:0] rotate_value;
   logic [6:0]            depth;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output stall, movement, next_top, rotate, rotate_addr,
      input  top, second, third, rotate_value, depth, overflow, underflow
   );

   modport slave (
      input  stall, movement, next_top, rotate, rotate_addr,
      output top, second, third, rotate_value, depth, overflow, underflow
   );
endinterface

// File: rtl/dstack.sv
// Shift-register data stack: entry 0 is the top, rewritten with next_top on every
// non-stalled cycle; tracks depth and sticky overflow/underflow flags.
module dstack #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 64
) (
   input logic     clk,
   input logic     reset,
   dstack_if.slave bus
);
   localparam int         AW      = $clog2(DEPTH);
   localparam logic [6:0] DEPTH_W = 7'(DEPTH);

   logic [WORD_WIDTH-1:0] entries_q [DEPTH];
   logic [WORD_WIDTH-1:0] entries_d [DEPTH];
   logic [6:0]            depth_q, depth_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  rot_in_range;
   logic [AW-1:0]         rot_idx;

   assign rot_in_range = ({1'b0, bus.rotate_addr} < DEPTH_W);
   assign rot_idx      = bus.rotate_addr[AW-1:0];

   always_comb begin
      entries_d   = entries_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (!bus.stall) begin
         case (bus.movement)
            2'b00: begin
               if (bus.rotate) begin
                  // Entries 1..k slide down one place; entry k's old value is the one lifted to top.
                  for (int i = 1; i < DEPTH; i++) begin
                     if (rot_in_range && i <= int'(bus.rotate_addr)) entries_d[i] = entries_q[i-1];
                  end
                  if ({1'b0, bus.rotate_addr} >= depth_q) underflow_d = 1'b1;
               end else if (depth_q == 7'd0) begin
                  depth_d = 7'd1;
               end
            end
            2'b01: begin
               for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
               if (depth_q == DEPTH_W) overflow_d = 1'b1;
               else                    depth_d    = depth_q + 7'd1;
            end
            2'b10: begin
               for (int i = 1; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
               entries_d[DEPTH-1] = '0;
               if (depth_q < 7'd2) begin
                  underflow_d = 1'b1;
                  depth_d     = 7'd1;
               end else begin
                  depth_d = depth_q - 7'd1;
               end
            end
            default: begin
               for (int i = 1; i < DEPTH - 2; i++) entries_d[i] = entries_q[i+2];
               entries_d[DEPTH-1] = '0;
               entries_d[DEPTH-2] = '0;
               if (depth_q < 7'd3) begin
                  underflow_d = 1'b1;
                  depth_d     = 7'd1;
               end else begin
                  depth_d = depth_q - 7'd2;
               end
            end
         endcase
         entries_d[0] = bus.next_top;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         depth_q     <= 7'd0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.top          = entries_q[0];
   assign bus.second       = entries_q[1];
   assign bus.rotate_value = rot_in_range ? entries_q[rot_idx] : '0;
   assign bus.depth        = depth_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   generate
      if (DEPTH > 2) begin : g_third
         assign bus.third = entries_q[2];
      end else begin : g_no_third
         assign bus.third = '0;
      end
   endgenerate

   // Rotate is only meaningful alongside a replace-top movement.
   rotate_with_movement : assert property (
      @(posedge clk) disable iff (reset) !(bus.rotate && bus.movement != 2'b00)
   );
endmodule
